// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use interlock,
// taken-branch flush, variable-latency data-memory freeze and pipeline statistics.
module pipe_hazard_ctrl #(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             mem_memread,
  input  logic             mem_memwrite,
  input  logic             mem_branch_taken,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_write,
  output logic             pc_sel_branch,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned WCW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_LIMIT - 1);

  localparam logic [0:0] S_RUN      = 1'b0;
  localparam logic [0:0] S_MEM_WAIT = 1'b1;

  logic [0:0]     state, state_nxt;
  logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
  logic           mem_access, load_use;
  logic           freeze, complete, set_err;
  logic           stall_inc, flush_inc;

  assign mem_access = mem_memread | mem_memwrite;
  assign load_use   = ex_memread & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

  always_comb begin
    freeze   = 1'b0;
    complete = 1'b0;
    if (state == S_RUN) begin
      freeze = mem_access & ~dmem_ready;
    end else begin
      freeze   = ~dmem_ready & (wait_cnt != WAIT_LAST);
      complete = ~freeze;
    end
  end

  // Pipeline controls; reset overrides everything, freeze masks branch and load-use.
  always_comb begin
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    idex_write    = 1'b1;
    exmem_write   = 1'b1;
    pc_sel_branch = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    memwb_bubble  = 1'b0;
    dmem_req      = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_flush  = 1'b1;
      memwb_bubble = 1'b1;
    end else begin
      dmem_req = ((state == S_RUN) & mem_access) | (state == S_MEM_WAIT);
      if (freeze) begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b1;
      end else if (mem_branch_taken) begin
        pc_sel_branch = 1'b1;
        ifid_flush    = 1'b1;
        idex_flush    = 1'b1;
        exmem_flush   = 1'b1;
      end else if (load_use) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    set_err      = 1'b0;
    if (freeze) begin
      state_nxt    = S_MEM_WAIT;
      wait_cnt_nxt = (state == S_RUN) ? '0 : wait_cnt + WCW'(1);
    end else if (complete) begin
      state_nxt    = S_RUN;
      wait_cnt_nxt = '0;
      set_err      = ~dmem_ready;
    end
  end

  assign stall_inc = ~reset & ~pc_write;
  assign flush_inc = ~reset & ~freeze & mem_branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_RUN;
      wait_cnt     <= '0;
      mem_error    <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (set_err) mem_error <= 1'b1;
      if (stall_inc && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_inc && (flush_events != '1)) flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline. It sits beside the IF_ID, ID_EX, EXE_MEM and MEM_WB pipeline registers and sequences them by generating their write-enable and flush/bubble controls from three sources:
- load-use hazards detected between ID and EX;
- taken branches resolved in MEM;
- variable-latency data-memory accesses, handled with a req/ready handshake.

It also keeps saturating stall and flush statistics and a sticky memory-timeout flag.

## Interface
Parameters:
- WAIT_LIMIT, 16, maximum number of frozen cycles for one data-memory access before it is abandoned (≥2).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- ex_memread  in  1  instruction in EX is a load.
- ex_rt  in  5  destination register of the instruction in EX.
- mem_memread  in  1  instruction in MEM reads data memory.
- mem_memwrite  in  1  instruction in MEM writes data memory.
- mem_branch_taken  in  1  branch in MEM resolved taken.
- dmem_ready  in  1  data memory completes the current access this cycle.
- dmem_req  out  1  data-memory access request.
- pc_write  out  1  PC load enable.
- pc_sel_branch  out  1  select the branch target as next PC.
- ifid_write  out  1  IF_ID load enable.
- ifid_flush  out  1  clear IF_ID.
- idex_write  out  1  ID_EX load enable.
- idex_flush  out  1  load a bubble into ID_EX.
- exmem_write  out  1  EXE_MEM load enable.
- exmem_flush  out  1  load a bubble into EXE_MEM.
- memwb_bubble  out  1  load a bubble into MEM_WB.
- mem_error  out  1  sticky data-memory timeout flag.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0.
- flush_events  out  CNT_W  saturating count of taken-branch flushes.

## Operation
Definitions:
- mem_access = mem_memread | mem_memwrite.
- load_use = ex_memread & (ex_rt≠0) & (ex_rt==id_rs | ex_rt==id_rt).

FSM has two states: RUN and MEM_WAIT. It holds a wait counter wait_cnt, which is ceil(log2(WAIT_LIMIT)) bits wide.

Default control values (any case not overridden below):
- pc_write, ifid_write, idex_write, exmem_write = 1.
- All flush/bubble outputs and pc_sel_branch = 0.

Cases are evaluated in priority order, highest first:
1. **Memory freeze.** Condition: (RUN & mem_access & !dmem_ready), or (MEM_WAIT & !dmem_ready & wait_cnt≠WAIT_LIMIT-1).
   - All write enables = 0; memwb_bubble = 1.
   - Branch and load-use are ignored this cycle.
   - Transitions: RUN→MEM_WAIT with wait_cnt←0; in MEM_WAIT, wait_cnt←wait_cnt+1.
2. **Memory completion.** Condition: MEM_WAIT & (dmem_ready | wait_cnt==WAIT_LIMIT-1).
   - Pipeline advances; next state RUN.
   - If dmem_ready=0 (timeout), mem_error←1.
   - Cases 3 and 4 are still evaluated in this cycle.
3. **Taken branch.** Condition: mem_branch_taken.
   - pc_sel_branch = 1; ifid_flush = 1; idex_flush = 1; exmem_flush = 1.
   - flush_events increments.
   - Overrides load-use.
4. **Load-use.** Condition: load_use.
   - pc_write = 0; ifid_write = 0; idex_flush = 1.
   - Stalls exactly one cycle: the load moves to MEM, so the hazard clears.

Other rules:
- dmem_req = (RUN & mem_access) | MEM_WAIT.
- A zero-wait access (dmem_ready in the same RUN cycle) causes no stall.
- stall_cycles increments, saturating at all-ones, on every non-reset cycle with pc_write=0.
- flush_events saturates at all-ones.
- mem_error is cleared only by reset.

## Timing
- All control outputs are combinational from the inputs and the current state, with zero-cycle latency. The state, wait_cnt, counters and mem_error are registered.
- Reset (sampled at the edge) sets: state RUN, wait_cnt 0, counters 0, mem_error 0.
- While reset is high, the controls are forced regardless of state: all write enables = 0; ifid_flush, idex_flush, exmem_flush, memwb_bubble = 1; dmem_req = 0; pc_sel_branch = 0.
- Reset during MEM_WAIT abandons the access and sets no error.
- Freeze length for an access acknowledged k cycles after entry (k<WAIT_LIMIT): k frozen cycles, advance on cycle k+1.
- Timeout: exactly WAIT_LIMIT frozen cycles; the pipeline advances on the next cycle with mem_error rising at that edge.
- Load-use: one cycle with pc_write=0.
- A branch concurrent with a load-use gives no stall, only the flush.

## Test plan
- **Load-use.** ex_memread=1, ex_rt=5, id_rs=5 for one cycle → pc_write=0, ifid_write=0, idex_flush=1 that cycle, stall_cycles=1 next cycle. With ex_rt=0 → no stall.
- **Taken branch.** mem_branch_taken=1 with load_use also true → pc_sel_branch=1, ifid/idex/exmem flush=1, pc_write=1, flush_events=1, stall_cycles unchanged.
- **Variable-latency memory.** mem_memread=1, dmem_ready low for 3 cycles then high → 3 cycles of all write enables=0 and memwb_bubble=1, dmem_req high for 4 cycles, advance on cycle 4, state back to RUN, stall_cycles=3.
- **Timeout.** WAIT_LIMIT=4, dmem_ready held 0 → 4 frozen cycles, advance on cycle 5, mem_error=1 afterwards, still 1 after a later clean access.
- **Freeze priority.** Branch arrives during MEM_WAIT → no flush while frozen; flush occurs on the completion cycle.
- **Reset mid-wait.** reset pulsed in MEM_WAIT → next cycle state RUN, counters 0, mem_error 0. During reset: all write enables=0, ifid_flush, idex_flush, exmem_flush, memwb_bubble=1, dmem_req=0.
